// File: rtl/c_fsm_pkg.sv
// c_fsm_pkg: state encodings and reset state shared by the c_fsm Mealy machine.
package c_fsm_pkg;
   typedef enum logic [2:0] {
      A = 3'b000,
      B = 3'b001,
      C = 3'b010,
      D = 3'b011,
      E = 3'b100
   } state_t;
   localparam state_t RESET_STATE = B;
endpackage

// File: rtl/c_fsm.sv
// c_fsm: five-state Mealy machine; y_out is combinational in (state, x_in).
module c_fsm
   import c_fsm_pkg::*;
(
   output logic y_out,
   input  logic x_in,
   input  logic clk,
   input  logic reset
);
   logic [2:0] r_state;
   logic [2:0] w_next;
   always_ff @(posedge clk)
      r_state <= reset ? RESET_STATE : w_next;
   // Illegal encodings fall through to the defaults: y_out=0, recover to B.
   always_comb begin
      w_next = RESET_STATE;
      y_out  = 1'b0;
      case (r_state)
         A:       begin w_next = x_in ? E : B; y_out = x_in;  end
         B:       begin w_next = x_in ? E : B; y_out = x_in;  end
         C:       begin w_next = x_in ? A : D; y_out = x_in;  end
         D:       begin w_next = x_in ? C : E; y_out = 1'b1;  end
         E:       begin w_next = x_in ? D : A; y_out = ~x_in; end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_c_fsm.sv
// tb_c_fsm: directed and randomized checks of c_fsm against a table-driven model.
module tb_c_fsm;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic x_in = 1'b0;
   logic y_out;
   int checks = 0;
   int errors = 0;
   int m_state;
   int nx [8][2];
   bit ny [8][2];

   c_fsm dut (.y_out(y_out), .x_in(x_in), .clk(clk), .reset(reset));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input bit x, input bit r, input string tag);
      x_in = x;
      reset = r;
      #1;
      chk({tag, "_y"}, {2'b00, y_out}, {2'b00, ny[m_state][x]});
      @(posedge clk);
      #1;
      m_state = r ? 1 : nx[m_state][x];
      chk({tag, "_st"}, dut.r_state, 3'(m_state));
   endtask

   initial begin
      // Model: states A..E are 0..4; anything else returns to B with output 0.
      for (int s = 0; s < 8; s++)
         for (int x = 0; x < 2; x++) begin
            nx[s][x] = 1;
            ny[s][x] = 1'b0;
         end
      nx[0][0] = 1; ny[0][0] = 0; nx[0][1] = 4; ny[0][1] = 1;
      nx[1][0] = 1; ny[1][0] = 0; nx[1][1] = 4; ny[1][1] = 1;
      nx[2][0] = 3; ny[2][0] = 0; nx[2][1] = 0; ny[2][1] = 1;
      nx[3][0] = 4; ny[3][0] = 1; nx[3][1] = 2; ny[3][1] = 1;
      nx[4][0] = 0; ny[4][0] = 1; nx[4][1] = 3; ny[4][1] = 0;

      reset = 1'b1;
      @(posedge clk);
      #1;
      m_state = 1;
      chk("reset_st", dut.r_state, 3'd1);
      chk("reset_y", {2'b00, y_out}, 3'd0);

      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "hold0");
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, "ones");
      step(1'b0, 1'b0, "d0");
      step(1'b0, 1'b0, "e0");
      step(1'b1, 1'b0, "a1");
      step(1'b1, 1'b0, "e1");
      step(1'b1, 1'b0, "d1");
      step(1'b0, 1'b0, "c0");
      step(1'b0, 1'b0, "d0b");
      step(1'b1, 1'b0, "e1b");
      step(1'b1, 1'b1, "midreset");
      step(1'b1, 1'b0, "after_rst");

      chk("in_e", dut.r_state, 3'd4);
      for (int i = 0; i < 4; i++) begin
         x_in = i[0];
         #1;
         chk("comb_y", {2'b00, y_out}, {2'b00, ~i[0]});
         chk("comb_st", dut.r_state, 3'd4);
      end

      force dut.r_state = 3'b110;
      #1;
      chk("illegal_y", {2'b00, y_out}, 3'd0);
      release dut.r_state;
      m_state = 6;
      step(1'b1, 1'b0, "illegal");

      for (int i = 0; i < 300; i++)
         step(1'($urandom), ($urandom_range(0, 19) == 0), "rand");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
